stopwatch_ctrl: RTL and testbench



---
 rtl/stopwatch_ctrl.sv | 172 +++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// stopwatch_ctrl : start/stop/lap/clear control FSM with mm:ss.cc BCD timebase
// Rev 1.0
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int MAX_MIN = 59
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic        btn_clr,
  output logic        running,
  output logic        lap_active,
  output logic        overflow,
  output logic [23:0] disp_bcd
);

  localparam logic [3:0] C_MAX_M10 = 4'(MAX_MIN / 10);
  localparam logic [3:0] C_MAX_M1  = 4'(MAX_MIN % 10);
  localparam logic [23:0] C_MAX_CNT = {C_MAX_M10, C_MAX_M1, 4'd5, 4'd9, 4'd9, 4'd9};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_LAP   = 2'd2,
    S_PAUSE = 2'd3
  } state_t;

  state_t      r_state;
  logic [23:0] r_live;
  logic [23:0] r_snap;
  logic        r_prev_ss;
  logic        r_prev_lap;
  logic        r_prev_clr;

  logic        w_p_ss;
  logic        w_p_lap;
  logic        w_p_clr;
  logic        w_cnt_en;
  logic        w_at_max;
  logic [23:0] w_live_inc;
  logic [23:0] w_live_step;

  assign w_p_ss   = btn_ss  & ~r_prev_ss;
  assign w_p_lap  = btn_lap & ~r_prev_lap;
  assign w_p_clr  = btn_clr & ~r_prev_clr;
  assign w_cnt_en = tick && ((r_state == S_RUN) || (r_state == S_LAP));
  assign w_at_max = (r_live == C_MAX_CNT);

  // Ripple-carry BCD increment: c1, c10, s1, s10 (0-5), m1, m10
  always_comb begin
    w_live_inc        = r_live;
    w_live_inc[3:0]   = r_live[3:0] + 4'd1;
    if (r_live[3:0] == 4'd9) begin
      w_live_inc[3:0] = 4'd0;
      w_live_inc[7:4] = r_live[7:4] + 4'd1;
      if (r_live[7:4] == 4'd9) begin
        w_live_inc[7:4]   = 4'd0;
        w_live_inc[11:8]  = r_live[11:8] + 4'd1;
        if (r_live[11:8] == 4'd9) begin
          w_live_inc[11:8]  = 4'd0;
          w_live_inc[15:12] = r_live[15:12] + 4'd1;
          if (r_live[15:12] == 4'd5) begin
            w_live_inc[15:12] = 4'd0;
            w_live_inc[19:16] = r_live[19:16] + 4'd1;
            if (r_live[19:16] == 4'd9) begin
              w_live_inc[19:16] = 4'd0;
              w_live_inc[23:20] = r_live[23:20] + 4'd1;
            end
          end
        end
      end
    end
  end

  assign w_live_step = w_cnt_en ? w_live_inc : r_live;

  // Outputs are assigned alongside each transition so they always track the next state
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_live     <= 24'h000000;
      r_snap     <= 24'h000000;
      r_prev_ss  <= 1'b1;
      r_prev_lap <= 1'b1;
      r_prev_clr <= 1'b1;
      overflow   <= 1'b0;
      running    <= 1'b0;
      lap_active <= 1'b0;
      disp_bcd   <= 24'h000000;
    end else begin
      r_prev_ss  <= btn_ss;
      r_prev_lap <= btn_lap;
      r_prev_clr <= btn_clr;

      if (w_cnt_en && w_at_max) begin
        // Saturate: hold the count, flag it and stop, overriding any press
        overflow   <= 1'b1;
        r_state    <= S_PAUSE;
        running    <= 1'b0;
        lap_active <= 1'b0;
        disp_bcd   <= r_live;
      end else begin
        case (r_state)
          S_IDLE: begin
            disp_bcd <= r_live;
            if (w_p_ss) begin
              r_state <= S_RUN;
              running <= 1'b1;
            end
          end
          S_RUN: begin
            r_live <= w_live_step;
            if (w_p_ss) begin
              r_state  <= S_PAUSE;
              running  <= 1'b0;
              disp_bcd <= w_live_step;
            end else if (w_p_lap) begin
              r_state    <= S_LAP;
              r_snap     <= r_live;
              lap_active <= 1'b1;
              disp_bcd   <= r_live;
            end else begin
              disp_bcd <= w_live_step;
            end
          end
          S_LAP: begin
            r_live <= w_live_step;
            if (w_p_ss) begin
              r_state    <= S_PAUSE;
              running    <= 1'b0;
              lap_active <= 1'b0;
              disp_bcd   <= w_live_step;
            end else if (w_p_lap) begin
              r_state    <= S_RUN;
              lap_active <= 1'b0;
              disp_bcd   <= w_live_step;
            end else begin
              disp_bcd <= r_snap;
            end
          end
          S_PAUSE: begin
            if (w_p_clr) begin
              r_state  <= S_IDLE;
              r_live   <= 24'h000000;
              r_snap   <= 24'h000000;
              overflow <= 1'b0;
              disp_bcd <= 24'h000000;
            end else if (w_p_ss && !overflow) begin
              r_state  <= S_RUN;
              running  <= 1'b1;
              disp_bcd <= r_live;
            end else begin
              disp_bcd <= r_live;
            end
          end
          default: begin
            r_state    <= S_IDLE;
            running    <= 1'b0;
            lap_active <= 1'b0;
            disp_bcd   <= r_live;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl : directed stimulus with a queued expectation scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        tick;
  logic        btn_ss;
  logic        btn_lap;
  logic        btn_clr;
  logic        running;
  logic        lap_active;
  logic        overflow;
  logic [23:0] disp_bcd;

  int n_tests;
  int n_fail;

  logic [26:0] exp_q[$];
  string       name_q[$];

  // Small minute limit keeps the overflow path reachable in a short run
  stopwatch_ctrl #(.MAX_MIN(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .btn_ss     (btn_ss),
    .btn_lap    (btn_lap),
    .btn_clr    (btn_clr),
    .running    (running),
    .lap_active (lap_active),
    .overflow   (overflow),
    .disp_bcd   (disp_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: registered outputs are stable at the falling edge
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [26:0] e;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_tests = n_tests + 1;
      if ({running, lap_active, overflow, disp_bcd} !== e) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got run=%0b lap=%0b ovf=%0b disp=%h, expected run=%0b lap=%0b ovf=%0b disp=%h",
                 nm, running, lap_active, overflow, disp_bcd, e[26], e[25], e[24], e[23:0]);
      end
    end
  end

  task automatic step(input logic rst_v, input logic ss, input logic lap,
                      input logic clr, input logic tk);
    @(negedge clk);
    rst_n   = rst_v;
    btn_ss  = ss;
    btn_lap = lap;
    btn_clr = clr;
    tick    = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic expect_out(input string nm, input logic r, input logic l,
                            input logic o, input logic [23:0] d);
    exp_q.push_back({r, l, o, d});
    name_q.push_back(nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    tick    = 1'b0;
    btn_ss  = 1'b1;
    btn_lap = 1'b0;
    btn_clr = 1'b0;

    // Reset with start/stop held high
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("reset", 1'b0, 1'b0, 1'b0, 24'h000000);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("held_through_reset", 1'b0, 1'b0, 1'b0, 24'h000000);

    // Release, then a real press with a coincident tick
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("idle_to_run_tick_dropped", 1'b1, 1'b0, 1'b0, 24'h000000);

    ticks(149);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("stop_tick_counted", 1'b0, 1'b0, 1'b0, 24'h000150);
    ticks(10);
    expect_out("pause_hold", 1'b0, 1'b0, 1'b0, 24'h000150);

    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("restart_tick_dropped", 1'b1, 1'b0, 1'b0, 24'h000150);
    ticks(87);
    expect_out("run_237", 1'b1, 1'b0, 1'b0, 24'h000237);

    // Lap freeze and release
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("lap_enter", 1'b1, 1'b1, 1'b0, 24'h000237);
    ticks(500);
    expect_out("lap_freeze", 1'b1, 1'b1, 1'b0, 24'h000237);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("lap_exit", 1'b1, 1'b0, 1'b0, 24'h000737);

    // Clear held while running is ignored
    repeat (20) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_out("clr_held_run", 1'b1, 1'b0, 1'b0, 24'h000757);

    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_out("ss_lap_same_cycle", 1'b0, 1'b0, 1'b0, 24'h000757);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("clr_in_pause", 1'b0, 1'b0, 1'b0, 24'h000000);

    // Mid-run reset while in LAP
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(1234);
    expect_out("run_1234", 1'b1, 1'b0, 1'b0, 24'h001234);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_out("lap_1234", 1'b1, 1'b1, 1'b0, 24'h001234);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_out("midrun_reset", 1'b0, 1'b0, 1'b0, 24'h000000);
    ticks(5);
    expect_out("idle_no_count", 1'b0, 1'b0, 1'b0, 24'h000000);

    // Carry chain and overflow at 01:59.99
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    ticks(5999);
    expect_out("pre_carry", 1'b1, 1'b0, 1'b0, 24'h005999);
    ticks(1);
    expect_out("minute_carry", 1'b1, 1'b0, 1'b0, 24'h010000);
    ticks(5999);
    expect_out("at_max", 1'b1, 1'b0, 1'b0, 24'h015999);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    expect_out("overflow_beats_lap", 1'b0, 1'b0, 1'b1, 24'h015999);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    expect_out("ss_ignored_ovf", 1'b0, 1'b0, 1'b1, 24'h015999);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_out("clr_after_ovf", 1'b0, 1'b0, 1'b0, 24'h000000);

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (exp_q.size() != 0) begin
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
